// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues one outstanding I-side request, buffers one instruction.
// Optional `FETCH_PERF_EN adds a saturating memory-wait cycle counter (fetch_wait_cycles).
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  redirect_e,
  input  logic [DATA_WIDTH-1:0] PCTarget_e,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] read_data_f,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic [DATA_WIDTH-1:0] PCPlus4_f,
  output logic                  valid_f
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_wait_cycles
`endif
);

  // state  | meaning
  // S_RUN  | normal fetch, request issued whenever the buffer can accept
  // S_DRAIN| redirect hit an outstanding request; its response is discarded
  typedef enum logic {S_RUN, S_DRAIN} state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] rdata_d, pcf_d, pc4_d;
  logic                  valid_d;
  logic                  req;

  // Request is suppressed in the reset cycle so nothing is issued from a stale PC.
  assign req       = !rst && ((state_q == S_DRAIN) || !valid_f || !stall_f);
  assign imem_req  = req;
  assign imem_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    rdata_d  = read_data_f;
    pcf_d    = PC_f;
    pc4_d    = PCPlus4_f;
    valid_d  = valid_f;
    case (state_q)
      S_RUN: begin
        if (redirect_e) begin
          valid_d = 1'b0;
          if (req && !imem_ready) begin
            target_d = PCTarget_e;
            state_d  = S_DRAIN;
          end else begin
            pc_d = PCTarget_e;
          end
        end else if (req && imem_ready) begin
          rdata_d = imem_rdata;
          pcf_d   = pc_q;
          pc4_d   = pc_q + PC_STEP;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_STEP;
        end else if (valid_f && !stall_f) begin
          valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        if (redirect_e) target_d = PCTarget_e;
        // A redirect coinciding with the dropped response still wins over the stored target.
        if (imem_ready) begin
          pc_d    = redirect_e ? PCTarget_e : target_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      target_q    <= '0;
      read_data_f <= '0;
      PC_f        <= '0;
      PCPlus4_f   <= '0;
      valid_f     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      read_data_f <= rdata_d;
      PC_f        <= pcf_d;
      PCPlus4_f   <= pc4_d;
      valid_f     <= valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_wait_cycles <= '0;
    end else if (req && !imem_ready && (fetch_wait_cycles != 32'hFFFF_FFFF)) begin
      fetch_wait_cycles <= fetch_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the pipelined-plus-cache core. It owns the program counter and issues one-at-a-time requests to the instruction cache/memory port. It holds one fetched instruction in an output buffer whose contents drive `read_data_f`, `PC_f` and `PCPlus4_f` into the fetch/decode pipeline register. It handles variable-latency cache responses, decode-side stalls and execute-stage redirects, including redirects that arrive while a request is still outstanding.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC and instruction data.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_f`  in  1  downstream stall; high = buffered instruction not consumed this cycle (same signal that drives the decode register `en` low).
- `redirect_e`  in  1  taken branch/jump from execute; single-cycle pulse.
- `PCTarget_e`  in  DATA_WIDTH  redirect target; sampled when `redirect_e`=1.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  DATA_WIDTH  fetch address.
- `imem_ready`  in  1  response valid; may be high in the same cycle `imem_req` rises (hit).
- `imem_rdata`  in  DATA_WIDTH  instruction; valid when `imem_ready`=1.
- `read_data_f`  out  DATA_WIDTH  buffered instruction.
- `PC_f`  out  DATA_WIDTH  address of buffered instruction.
- `PCPlus4_f`  out  DATA_WIDTH  `PC_f`+4.
- `valid_f`  out  1  buffer holds a live instruction; the hazard unit converts `valid_f`=0 into a decode bubble.

## Operation
- Registers: `pc_q` (next fetch address), instruction buffer (`read_data_f`, `PC_f`, `PCPlus4_f`, `valid_f`), `state`, `target_q`.
- consume = `valid_f` & !`stall_f`.
- States:
  - RUN: normal fetch.
  - DRAIN: a redirect hit an outstanding request; that response is discarded.
- RUN behaviour:
  - `imem_req` = !`valid_f` | !`stall_f`.
  - `imem_addr` = `pc_q`.
  - Once raised, `imem_req` stays high with a stable address until `imem_ready`. The buffer can only fill on a response, so this holds by construction; the bench asserts it.
- Capture (RUN, `imem_req` & `imem_ready` & !`redirect_e`):
  - `read_data_f` <= `imem_rdata`, `PC_f` <= `pc_q`, `PCPlus4_f` <= `pc_q`+4, `valid_f` <= 1.
  - `pc_q` <= `pc_q`+4.
- Consume without capture: `valid_f` <= 0.
- Redirect (`redirect_e`=1) has priority over capture and stall:
  - `valid_f` <= 0.
  - If `imem_req` & !`imem_ready`: `target_q` <= `PCTarget_e`, go to DRAIN.
  - Otherwise (no request, or response arriving this cycle, which is dropped): `pc_q` <= `PCTarget_e`, stay in RUN.
- DRAIN behaviour:
  - `imem_req`=1, `imem_addr`=`pc_q` (old address); `valid_f` held 0.
  - On `imem_ready`: data dropped, `pc_q` <= `target_q`, go to RUN.
  - A new `redirect_e` in DRAIN overwrites `target_q` (last redirect wins).
- Arithmetic: PC increment is modulo 2^DATA_WIDTH and wraps silently. Targets are not checked for alignment.
- Non-valid outputs hold their last values; consumers qualify with `valid_f`.

## Timing
- Reset: `pc_q`=RESET_PC, state RUN, `valid_f`=0, `read_data_f`=`PC_f`=`PCPlus4_f`=0, `target_q`=0. `imem_req` is 0 during the reset cycle and high in the first cycle after it.
- Zero-wait memory (ready same cycle): instruction at address A is requested in cycle N and appears with `valid_f` in N+1. Sustained throughput is one instruction per cycle while `stall_f`=0.
- k wait cycles: `valid_f` rises k cycles later.
- Redirect in cycle N, no outstanding miss: `valid_f`=0 in N+1, target requested in N+1.
- Redirect during a miss: the target is requested in the cycle after the dropped response.
- `stall_f` with a full buffer: `imem_req`=0 and all outputs are frozen.
- Simultaneous consume and capture: the buffer is replaced, with no bubble.
- `rst` asserted mid-miss or in DRAIN: reset values the next cycle. The memory side must tolerate an abandoned request, and any late `imem_ready` after reset is treated as the response to the new RESET_PC request only if `imem_req` is high.

## Configuration
- `FETCH_PERF_EN`: when defined, adds output `fetch_wait_cycles` (32-bit).
  - Increments in every cycle with `imem_req` & !`imem_ready` (both states), saturates at 32'hFFFF_FFFF, and resets to 0 on `rst`.
- When `FETCH_PERF_EN` is undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset then zero-wait memory, `stall_f`=0 -> `PC_f` = 0, 4, 8, 12 on consecutive cycles starting in cycle 2 after reset release, `valid_f`=1 continuously, `PCPlus4_f`=`PC_f`+4.
- 3-cycle miss at 0x8 -> `imem_addr`=0x8 with `imem_req` held for 4 cycles, `valid_f`=0 for 3 cycles, then `PC_f`=0x8.
- `stall_f`=1 for 5 cycles with a full buffer -> `imem_req`=0, outputs frozen, no PC advance; on release the next address is fetched with no lost instruction.
- Redirect to 0x100 on a zero-wait hit -> `valid_f`=0 in the next cycle, then `PC_f`=0x100; the hit data is never presented.
- Redirect to 0x200 during a 4-cycle miss, then a second redirect to 0x300 in DRAIN -> the old response is dropped and the next presented `PC_f`=0x300.
- With `FETCH_PERF_EN`: 2 misses of 3 wait cycles each -> `fetch_wait_cycles`=6; `rst` -> 0.
